imac_haar: RTL and testbench

Inverse single-level Haar stage. It is the reconstruction counterpart of the forward Haar MAC.
- Accepts one packed coefficient pair per beat: approximation L and detail H.
- Emits the reconstructed packed pixel pair: even sample A, odd sample B.
- Sits in the IDWT path, between the coefficient buffer read-out and the row/column re-interleaver.
- Pointers pass through alongside the data.
- Two-stage pipeline with valid/ready backpressure and a saturation event counter.

---
 rtl/dwt_pkg.sv | 22 ++
 rtl/sat_counter16.sv | 21 ++
 rtl/imac_haar.sv | 99 +++++++++
 tb/tb_imac_haar.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared constants and helpers for the DWT / IDWT datapath blocks.
// Byte lanes of packed pixel and coefficient pairs.
package dwt_pkg;

    localparam int PIX_W  = 8;
    localparam int PAIR_W = 16;

    localparam int L_MSB = 15;
    localparam int L_LSB = 8;
    localparam int H_MSB = 7;
    localparam int H_LSB = 0;

    typedef struct packed {
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
    } pix_pair_t;

    function automatic int ptr_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones.
// A synchronous clear takes priority over a same-cycle increment.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/imac_haar.sv
// Inverse single-level Haar stage: (L, H) -> (A, B) with clamping.
// Two-stage pipeline under one global advance enable.
module imac_haar
    import dwt_pkg::*;
#(
    parameter  int HEIGHT = 256,
    parameter  int WIDTH  = 256,
    localparam int PW     = ptr_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAIR_W-1:0] coeff_input,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [PW-1:0]     i_row_column_pointer,
    input  logic [PW-1:0]     i_pixel_pointer,
    output logic [PAIR_W-1:0] pixel_output,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [PW-1:0]     o_row_column_pointer,
    output logic [PW-1:0]     o_pixel_pointer,
    input  logic              sat_clear,
    output logic [15:0]       sat_count
);

    if (HEIGHT < 2) begin : g_height_chk
        $error("imac_haar: HEIGHT must be at least 2");
    end

    logic             en;
    logic [PIX_W-1:0] l_in;
    logic [PIX_W-1:0] h_in;

    logic             s1_valid;
    logic [PIX_W:0]   s1_sum;
    logic             s1_ge;
    logic [PIX_W-1:0] s1_dif;
    logic [PW-1:0]    s1_rc;
    logic [PW-1:0]    s1_px;

    pix_pair_t        pix_q;
    logic             sat_inc;

    assign en      = ~o_valid | o_ready;
    assign i_ready = en;
    assign l_in    = coeff_input[L_MSB:L_LSB];
    assign h_in    = coeff_input[H_MSB:H_LSB];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ge    <= 1'b0;
            s1_dif   <= '0;
            s1_rc    <= '0;
            s1_px    <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sum <= {1'b0, l_in} + {1'b0, h_in};
                s1_ge  <= (l_in >= h_in);
                s1_dif <= l_in - h_in;
                s1_rc  <= i_row_column_pointer;
                s1_px  <= i_pixel_pointer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid              <= 1'b0;
            pix_q                <= '0;
            o_row_column_pointer <= '0;
            o_pixel_pointer      <= '0;
        end else if (en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                pix_q.a              <= s1_sum[PIX_W] ? 8'hFF : s1_sum[PIX_W-1:0];
                pix_q.b              <= s1_ge ? s1_dif : 8'h00;
                o_row_column_pointer <= s1_rc;
                o_pixel_pointer      <= s1_px;
            end
        end
    end

    assign pixel_output = pix_q;

    // Counts beats where either output lane was clamped.
    assign sat_inc = en & s1_valid & (s1_sum[PIX_W] | ~s1_ge);

    sat_counter16 u_sat (
        .clk   (clk),
        .rst   (rst),
        .clr   (sat_clear),
        .inc   (sat_inc),
        .count (sat_count)
    );

endmodule

// File: tb/tb_imac_haar.sv
// Directed self-checking bench for imac_haar.
// Expected values are hand-computed from the reconstruction formulas.
module tb_imac_haar;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   coeff_input;
    logic          i_valid;
    logic          i_ready;
    logic [PW-1:0] i_row_column_pointer;
    logic [PW-1:0] i_pixel_pointer;
    logic [15:0]   pixel_output;
    logic          o_valid;
    logic          o_ready;
    logic [PW-1:0] o_row_column_pointer;
    logic [PW-1:0] o_pixel_pointer;
    logic          sat_clear;
    logic [15:0]   sat_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imac_haar #(.HEIGHT(256), .WIDTH(256)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .coeff_input          (coeff_input),
        .i_valid              (i_valid),
        .i_ready              (i_ready),
        .i_row_column_pointer (i_row_column_pointer),
        .i_pixel_pointer      (i_pixel_pointer),
        .pixel_output         (pixel_output),
        .o_valid              (o_valid),
        .o_ready              (o_ready),
        .o_row_column_pointer (o_row_column_pointer),
        .o_pixel_pointer      (o_pixel_pointer),
        .sat_clear            (sat_clear),
        .sat_count            (sat_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] l, input logic [7:0] h,
                         input logic [7:0] rc, input logic [7:0] px);
        coeff_input          = {l, h};
        i_row_column_pointer = rc;
        i_pixel_pointer      = px;
        i_valid              = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pix,
                           input logic [7:0] rc, input logic [7:0] px);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_pix"}, {16'd0, pixel_output}, {16'd0, pix});
        chk({tag, "_ptr"},
            {16'd0, o_row_column_pointer, o_pixel_pointer},
            {16'd0, rc, px});
    endtask

    initial begin
        rst = 1'b0;
        coeff_input = '0;
        i_valid = 1'b0;
        i_row_column_pointer = '0;
        i_pixel_pointer = '0;
        o_ready = 1'b1;
        sat_clear = 1'b0;
        tick();
        tick();

        chk("rst_ovalid", {31'd0, o_valid}, 32'd0);
        chk("rst_pix", {16'd0, pixel_output}, 32'd0);
        chk("rst_ptr", {16'd0, o_row_column_pointer, o_pixel_pointer}, 32'd0);
        chk("rst_sat", {16'd0, sat_count}, 32'd0);
        chk("rst_iready", {31'd0, i_ready}, 32'd1);
        rst = 1'b1;
        tick();

        // Plain beat: 0x4B+0x19=0x64, 0x4B-0x19=0x32
        drive(8'h4B, 8'h19, 8'd3, 8'd7);
        tick();
        i_valid = 1'b0;
        chk("lat1_ovalid", {31'd0, o_valid}, 32'd0);
        tick();
        chk_out("b1", 16'h6432, 8'd3, 8'd7);
        chk("b1_sat", {16'd0, sat_count}, 32'd0);
        tick();
        chk("bubble_ovalid", {31'd0, o_valid}, 32'd0);
        chk("bubble_pix", {16'd0, pixel_output}, 32'h6432);

        // A clamps high
        drive(8'hF0, 8'h20, 8'd1, 8'd2);
        tick();
        i_valid = 1'b0;
        tick();
        chk_out("b2", 16'hFFD0, 8'd1, 8'd2);
        chk("b2_sat", {16'd0, sat_count}, 32'd1);

        // B clamps low
        drive(8'h10, 8'h20, 8'd4, 8'd5);
        tick();
        i_valid = 1'b0;
        tick();
        chk_out("b3", 16'h3000, 8'd4, 8'd5);
        chk("b3_sat", {16'd0, sat_count}, 32'd2);

        // L == H: sum overflows to 0x100, difference exactly 0
        drive(8'h80, 8'h80, 8'd9, 8'd9);
        tick();
        i_valid = 1'b0;
        tick();
        chk_out("eq", 16'hFF00, 8'd9, 8'd9);
        chk("eq_sat", {16'd0, sat_count}, 32'd3);

        // Stream of 4 beats: L=0x10+k, H=1 -> A=0x11+k, B=0x0F+k
        drive(8'h10, 8'h01, 8'd0, 8'd8);
        tick();
        drive(8'h11, 8'h01, 8'd1, 8'd9);
        tick();
        chk_out("s0", 16'h110F, 8'd0, 8'd8);
        drive(8'h12, 8'h01, 8'd2, 8'd10);
        tick();
        chk_out("s1", 16'h1210, 8'd1, 8'd9);
        drive(8'h13, 8'h01, 8'd3, 8'd11);
        o_ready = 1'b0;
        #1;
        chk("stall_iready", {31'd0, i_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall_hold", 16'h1210, 8'd1, 8'd9);
            chk("stall_iready_h", {31'd0, i_ready}, 32'd0);
        end
        o_ready = 1'b1;
        #1;
        chk("unstall_iready", {31'd0, i_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        chk_out("s2", 16'h1311, 8'd2, 8'd10);
        tick();
        chk_out("s3", 16'h1412, 8'd3, 8'd11);
        tick();
        chk("s_drain", {31'd0, o_valid}, 32'd0);
        chk("s_sat", {16'd0, sat_count}, 32'd3);

        // Asynchronous reset with two beats in flight
        drive(8'h20, 8'h10, 8'd6, 8'd6);
        tick();
        drive(8'h21, 8'h10, 8'd7, 8'd7);
        tick();
        i_valid = 1'b0;
        chk("pre_rst_ovalid", {31'd0, o_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_ovalid", {31'd0, o_valid}, 32'd0);
        chk("async_sat", {16'd0, sat_count}, 32'd0);
        chk("async_pix", {16'd0, pixel_output}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_empty", {31'd0, o_valid}, 32'd0);
        drive(8'h05, 8'h03, 8'd5, 8'd6);
        tick();
        i_valid = 1'b0;
        chk("post_rst_lat1", {31'd0, o_valid}, 32'd0);
        tick();
        chk_out("post_rst", 16'h0802, 8'd5, 8'd6);

        // 65535 clamping beats (L<H) drive sat_count to its ceiling
        drive(8'h00, 8'h01, 8'd0, 8'd0);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        chk("sat_full", {16'd0, sat_count}, 32'h0000FFFF);
        drive(8'h00, 8'h01, 8'd0, 8'd0);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk("sat_hold", {16'd0, sat_count}, 32'h0000FFFF);

        // Clear coincides with a clamping beat loading stage 2
        drive(8'hFF, 8'h01, 8'd2, 8'd3);
        tick();
        i_valid = 1'b0;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk_out("clr_beat", 16'hFFFE, 8'd2, 8'd3);
        chk("sat_clear_wins", {16'd0, sat_count}, 32'd0);
        drive(8'h01, 8'h02, 8'd0, 8'd1);
        tick();
        i_valid = 1'b0;
        tick();
        chk_out("after_clr", 16'h0300, 8'd0, 8'd1);
        chk("sat_after_clr", {16'd0, sat_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
